// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing recovery.
// Rebuilds pixel coordinates, measures raster timing and tracks lock.
module vga_sync_decoder #(
    parameter int CNT_W       = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vga_h_sync,
    input  logic             vga_v_sync,
    input  logic             in_display,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_valid,
    output logic             line_start,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] active_w,
    output logic [CNT_W-1:0] active_h,
    output logic             locked,
    output logic             timing_err
);

    localparam int MW = $clog2(LOCK_FRAMES + 1);

    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_N = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == MAX) ? MAX : v + ONE;
    endfunction

    // stage-1 input samples
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic de_q, de_d;
    logic hs_prev_q, hs_prev_d;
    logic vs_prev_q, vs_prev_d;

    // raster counters
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] l_cnt_q, l_cnt_d;
    logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0] y_cnt_q, y_cnt_d;

    // registered outputs
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic             pix_valid_q, pix_valid_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [CNT_W-1:0] h_total_q, h_total_d;
    logic [CNT_W-1:0] v_total_q, v_total_d;
    logic [CNT_W-1:0] active_w_q, active_w_d;
    logic [CNT_W-1:0] active_h_q, active_h_d;
    logic             timing_err_q, timing_err_d;

    // lock tracking
    state_t           state_q, state_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic             first_q, first_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] prev_h_q, prev_h_d;
    logic [CNT_W-1:0] prev_v_q, prev_v_d;
    logic             prev_ok_q, prev_ok_d;

    // edge events and derived measurements
    logic             h_rise;
    logic             v_rise;
    logic             v_ok;
    logic             v_orphan;
    logic             h_sat;
    logic             x_any;
    logic [CNT_W-1:0] line_len;
    logic [CNT_W-1:0] l_len;
    logic [CNT_W-1:0] y_fin;
    logic [CNT_W-1:0] x_base;
    logic [CNT_W-1:0] y_base;
    logic             len_bad;
    logic             frame_good;
    logic             match_ok;
    logic [MW-1:0]    match_inc;
    logic             lock_err;

    assign h_rise     = hs_q & ~hs_prev_q;
    assign v_rise     = vs_q & ~vs_prev_q;
    assign v_ok       = h_rise & v_rise;
    assign v_orphan   = v_rise & ~h_rise;
    assign h_sat      = (h_cnt_q == (MAX - ONE)) & ~h_rise;
    assign x_any      = |x_cnt_q;
    assign line_len   = sat_inc(h_cnt_q);
    assign l_len      = sat_inc(l_cnt_q);
    assign y_fin      = x_any ? sat_inc(y_cnt_q) : y_cnt_q;
    assign x_base     = h_rise ? '0 : x_cnt_q;
    assign y_base     = h_rise ? (v_ok ? '0 : y_fin) : y_cnt_q;
    assign len_bad    = ~first_q & (line_len != ref_q);
    assign frame_good = ~bad_q & ~len_bad;
    assign match_inc  = match_q + MW'(1);
    assign match_ok   = frame_good & prev_ok_q &
                        (line_len == prev_h_q) &
                        (l_len == prev_v_q);
    assign lock_err   = (h_rise & (line_len != prev_h_q)) |
                        (v_ok & (l_len != prev_v_q)) |
                        (l_cnt_q > prev_v_q) |
                        h_sat | v_orphan;

    // next values for input samples and raster counters
    always_comb begin
        hs_d      = vga_h_sync;
        vs_d      = vga_v_sync;
        de_d      = in_display;
        hs_prev_d = hs_q;
        vs_prev_d = vs_q;
        seen_d    = seen_q | v_ok;
        h_cnt_d   = h_rise ? '0 : sat_inc(h_cnt_q);
        l_cnt_d   = l_cnt_q;
        if (v_ok) begin
            l_cnt_d = '0;
        end else if (h_rise) begin
            l_cnt_d = sat_inc(l_cnt_q);
        end
        x_cnt_d = de_q ? sat_inc(x_base) : x_base;
        y_cnt_d = y_base;
    end

    // input sampling and raster counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            seen_q    <= 1'b0;
            h_cnt_q   <= '0;
            l_cnt_q   <= '0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            seen_q    <= seen_d;
            h_cnt_q   <= h_cnt_d;
            l_cnt_q   <= l_cnt_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
        end
    end

    // coordinate, pulse and measurement outputs
    always_comb begin
        pix_x_d       = x_base;
        pix_y_d       = y_base;
        pix_valid_d   = de_q & (seen_q | v_ok);
        line_start_d  = h_rise;
        frame_start_d = v_ok;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        active_w_d    = active_w_q;
        active_h_d    = active_h_q;
        if (h_rise) begin
            h_total_d = line_len;
        end
        if (v_ok) begin
            v_total_d = l_len;
        end
        if (h_rise && x_any) begin
            active_w_d = x_cnt_q;
        end
        if (v_ok && seen_q) begin
            active_h_d = y_fin;
        end
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            active_w_q    <= '0;
            active_h_q    <= '0;
        end else begin
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            active_w_q    <= active_w_d;
            active_h_q    <= active_h_d;
        end
    end

    // lock FSM: next state and frame qualification
    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        ref_d        = ref_q;
        first_d      = first_q;
        bad_d        = bad_q;
        prev_h_d     = prev_h_q;
        prev_v_d     = prev_v_q;
        prev_ok_d    = prev_ok_q;
        timing_err_d = 1'b0;
        unique case (state_q)
            SEARCH: begin
                ref_d     = '0;
                match_d   = '0;
                first_d   = 1'b1;
                bad_d     = 1'b0;
                prev_ok_d = 1'b0;
                if (v_ok) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (h_sat) begin
                    state_d = SEARCH;
                end else if (h_rise) begin
                    if (first_q) begin
                        ref_d   = line_len;
                        first_d = 1'b0;
                    end else if (line_len != ref_q) begin
                        bad_d = 1'b1;
                    end
                    if (v_ok) begin
                        match_d   = match_ok ? match_inc : '0;
                        prev_h_d  = line_len;
                        prev_v_d  = l_len;
                        prev_ok_d = frame_good;
                        first_d   = 1'b1;
                        bad_d     = 1'b0;
                        if (match_ok && (match_inc == LOCK_N)) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (lock_err) begin
                    timing_err_d = 1'b1;
                    state_d      = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // lock FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            match_q      <= '0;
            ref_q        <= '0;
            first_q      <= 1'b1;
            bad_q        <= 1'b0;
            prev_h_q     <= '0;
            prev_v_q     <= '0;
            prev_ok_q    <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            ref_q        <= ref_d;
            first_q      <= first_d;
            bad_q        <= bad_d;
            prev_h_q     <= prev_h_d;
            prev_v_q     <= prev_v_d;
            prev_ok_q    <= prev_ok_d;
            timing_err_q <= timing_err_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign active_w    = active_w_q;
    assign active_h    = active_h_q;
    assign locked      = (state_q == LOCKED);
    assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder.
// Drives a small raster (40 x 16, active 24 x 10) through lock scenarios.
module tb_vga_sync_decoder;

    localparam int CNT_W = 10;
    localparam int H     = 40;
    localparam int HS    = 4;
    localparam int V     = 16;
    localparam int VS    = 2;
    localparam int X0    = 8;
    localparam int AW    = 24;
    localparam int Y0    = 3;
    localparam int AH    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vga_h_sync = 1'b0;
    logic vga_v_sync = 1'b0;
    logic in_display = 1'b0;
    logic [CNT_W-1:0] pix_x, pix_y, h_total, v_total, active_w, active_h;
    logic pix_valid, line_start, frame_start, locked, timing_err;
    logic [95:0] outs;

    assign outs = {31'd0, pix_x, pix_y, pix_valid, line_start, frame_start,
                   h_total, v_total, active_w, active_h, locked, timing_err};

    vga_sync_decoder #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vga_h_sync(vga_h_sync),
        .vga_v_sync(vga_v_sync),
        .in_display(in_display),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_valid(pix_valid),
        .line_start(line_start),
        .frame_start(frame_start),
        .h_total(h_total),
        .v_total(v_total),
        .active_w(active_w),
        .active_h(active_h),
        .locked(locked),
        .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int hx = 0, vy = 0, cur_len = H, fnum = 0, step_n = 0;
    int drv_x = 0, drv_y = 0;
    bit run_en = 0, glitch_req = 0, hold_h = 0, vs_force = 0;
    int acc_pv = 0, acc_err = 0, acc_fs = 0;
    int err_step = -1, err_h = 0;
    bit err_wide = 0, prev_err = 0;
    int s0 = 0;

    task automatic check(input string tag, input logic [95:0] obs,
                         input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_n++;
        acc_pv  += int'(pix_valid);
        acc_err += int'(timing_err);
        acc_fs  += int'(frame_start);
        if (timing_err) begin
            if (err_step < 0) err_step = step_n;
            err_h = int'(h_total);
            if (prev_err) err_wide = 1;
        end
        prev_err = timing_err;
        if (!run_en) begin
            vga_h_sync = 1'b0;
            vga_v_sync = vs_force;
            in_display = 1'b0;
            return;
        end
        if (hx == 0) begin
            cur_len = glitch_req ? H - 1 : H;
            glitch_req = 0;
            if (vy == 0) fnum++;
        end
        vga_h_sync = !hold_h && (hx < HS);
        vga_v_sync = vs_force || (!hold_h && (vy < VS));
        in_display = (hx >= X0) && (hx < X0 + AW) &&
                     (vy >= Y0) && (vy < Y0 + AH);
        drv_x = hx;
        drv_y = vy;
        hx++;
        if (hx >= cur_len) begin
            hx = 0;
            vy = (vy == V - 1) ? 0 : vy + 1;
        end
    endtask

    task automatic goto(input int x, input int y);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(drv_x == x && drv_y == y) && k < 4000);
        if (!(drv_x == x && drv_y == y))
            check("goto_reach", {drv_x, drv_y}, {x, y});
    endtask

    task automatic run_until_fs(input int n);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (fnum < n && k < 20000);
        if (fnum < n) check("fs_reach", fnum, n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs, 96'd0);
        rst_n = 1'b1;

        // orphan vsync while searching
        acc_fs = 0; acc_err = 0;
        repeat (2) step();
        vs_force = 1;
        repeat (3) step();
        vs_force = 0;
        repeat (6) step();
        check("srch_orphan_fs", acc_fs, 0);
        check("srch_orphan_err", acc_err, 0);
        check("srch_orphan_lock", locked, 0);

        // nominal lock
        run_en = 1; hx = 0; vy = 0;
        run_until_fs(4);
        step();
        check("lock_pre", locked, 0);
        step();
        check("lock_rise", locked, 1);
        check("lock_fs", frame_start, 1);
        check("h_total", h_total, H);
        check("v_total", v_total, V);
        check("active_w", active_w, AW);
        check("active_h", active_h, AH);

        // coordinates
        goto(X0, Y0);
        step(); step();
        check("first_x", pix_x, 0);
        check("first_y", pix_y, 0);
        check("first_valid", pix_valid, 1);
        goto(X0 + AW - 1, Y0 + AH - 1);
        step(); step();
        check("last_x", pix_x, AW - 1);
        check("last_y", pix_y, AH - 1);
        check("last_valid", pix_valid, 1);
        step();
        check("blank_valid", pix_valid, 0);
        goto(0, 14);
        step(); step();
        check("ls_pulse", line_start, 1);
        check("ls_no_fs", frame_start, 0);
        step();
        check("ls_width", line_start, 0);

        // shortened line while locked
        goto(0, 5);
        acc_err = 0; err_step = -1; err_wide = 0;
        glitch_req = 1;
        goto(0, 8);
        check("glitch_err_cnt", acc_err, 1);
        check("glitch_err_wide", err_wide, 0);
        check("glitch_h_total", err_h, H - 1);
        check("glitch_unlock", locked, 0);
        run_until_fs(9);
        step();
        check("relock_pre", locked, 0);
        step();
        check("relock", locked, 1);

        // orphan vsync while locked
        goto(20, 8);
        acc_err = 0;
        vs_force = 1;
        repeat (3) step();
        vs_force = 0;
        repeat (3) step();
        check("lk_orphan_err", acc_err, 1);
        check("lk_orphan_unlock", locked, 0);
        run_until_fs(14);
        step(); step();
        check("relock2", locked, 1);

        // hsync stall while locked
        goto(0, 4);
        s0 = step_n;
        goto(10, 4);
        hold_h = 1;
        acc_err = 0; err_step = -1;
        for (int k = 0; k < 1200 && err_step < 0; k++) step();
        check("timeout_delay", err_step - s0, 1025);
        check("timeout_unlock", locked, 0);
        repeat (2) step();
        hold_h = 0;

        // reset in the middle of a frame
        run_until_fs(fnum + 1);
        goto(X0 + 10, Y0 + 5);
        step(); step();
        check("pre_rst_valid", pix_valid, 1);
        check("pre_rst_x", pix_x, 10);
        check("pre_rst_y", pix_y, 5);
        #1 rst_n = 1'b0;
        #1 check("rst_async", outs, 96'd0);
        step();
        rst_n = 1'b1;
        acc_pv = 0;
        run_until_fs(fnum + 1);
        check("rst_pv_hold", acc_pv, 0);
        goto(X0, Y0);
        step(); step();
        check("rst_first_valid", pix_valid, 1);
        check("rst_first_x", pix_x, 0);
        check("rst_first_y", pix_y, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side VGA timing decoder for the background module. It consumes the sync pulses and display-enable produced by the VGA timing generator, or an equivalent upstream source, and recovers per-pixel coordinates within the active area. It measures line length, frame length and active width/height, and declares lock once the timing is stable over several frames. Downstream pixel consumers, such as capture, overlay and test checkers, use its coordinates and `locked` flag instead of re-deriving timing.

## Interface
Parameters:
- `CNT_W`, 10: width of all counters and measured values.
- `LOCK_FRAMES`, 2: consecutive matching complete frames required to assert `locked`.

Ports:
- `clk` in 1: pixel clock. Single clock domain; all inputs are synchronous to it.
- `rst_n` in 1: reset, asynchronous and active-low.
- `vga_h_sync` in 1: active-high line-start marker. Only the rising edge is significant.
- `vga_v_sync` in 1: active-high frame-start marker. Valid only when its rising edge coincides with a `vga_h_sync` rising edge.
- `in_display` in 1: active-high display-enable.
- `pix_x` out CNT_W: active column, 0-based.
- `pix_y` out CNT_W: active row, 0-based.
- `pix_valid` out 1: `pix_x`/`pix_y` are valid for the current pixel.
- `line_start` out 1: one-cycle pulse per accepted line start.
- `frame_start` out 1: one-cycle pulse per accepted frame start.
- `h_total` out CNT_W: clocks per line, measured at the last accepted line start.
- `v_total` out CNT_W: lines per frame, measured at the last accepted frame start.
- `active_w` out CNT_W: `in_display` clocks in the last line that had any.
- `active_h` out CNT_W: lines containing `in_display` in the last complete frame.
- `locked` out 1: timing stable.
- `timing_err` out 1: one-cycle pulse on loss of lock.

## Operation
- Stage 1 registers `vga_h_sync`, `vga_v_sync` and `in_display`, and keeps the previous sync samples.
  - `h_rise`: rising edge of the registered `vga_h_sync`.
  - `v_rise`: rising edge of the registered `vga_v_sync`.
  - `v_ok`: `h_rise` and `v_rise` in the same cycle.
- `h_cnt` counts clocks since the last `h_rise` and saturates at 2^CNT_W−1.
  - On `h_rise`, `h_total` is set to `h_cnt`+1 and `h_cnt` is set to 0.
- `l_cnt` counts `h_rise` events since the last `v_ok`.
  - On `v_ok`, `v_total` is set to `l_cnt`+1 and `l_cnt` is set to 0.
- Per line, an x counter counts `in_display` cycles.
  - `pix_x` equals the x count before increment.
  - At the line end, a nonzero x count is copied to `active_w` and the row counter increments.
  - `pix_y` equals the row count.
  - The row counter clears on `v_ok`; its final value goes to `active_h`.
- `pix_valid` = registered `in_display` AND at least one `v_ok` seen since reset. It is independent of `locked`.
- FSM states: SEARCH, MEASURE, LOCKED. Reset state is SEARCH.
  - **SEARCH:** `v_ok` moves to MEASURE. The reference line length is cleared and `match_cnt` is set to 0.
  - **MEASURE:**
    - The first line of each frame sets the reference line length. Any later line in that frame with a different length marks the frame bad.
    - On `v_ok`:
      - If the frame is good and has the same `h_total`/`v_total` as the previous complete frame, `match_cnt` increments.
      - Otherwise `match_cnt` is set to 0.
    - When `match_cnt` reaches `LOCK_FRAMES`, the FSM moves to LOCKED.
    - Saturation of `h_cnt` moves the FSM to SEARCH with no `timing_err`.
  - **LOCKED:** any of the following pulses `timing_err`, drops `locked` and moves the FSM to SEARCH:
    - a line length different from the locked `h_total`;
    - a `v_ok` with a line count different from the locked `v_total`;
    - `l_cnt` exceeding the locked `v_total`;
    - `h_cnt` saturation;
    - `v_rise` without `h_rise`.
- `v_rise` without `h_rise` is ignored in SEARCH and MEASURE.
- `locked` = (state == LOCKED).

## Timing
- Reset values: every output is 0 and the FSM is in SEARCH. Assertion of `rst_n` takes effect asynchronously and clears all state.
- Fixed latency of 2 clocks from an input pin to `pix_*`, `line_start`, `frame_start` and `timing_err`.
- `h_total`, `v_total`, `active_w` and `active_h` update in the same cycle as the corresponding `line_start`/`frame_start`.
- Lock sequence with `LOCK_FRAMES`=2:
  - `v_ok` #1 enters MEASURE.
  - `v_ok` #2 records frame 1.
  - `v_ok` #3 and #4 each match.
  - `locked` rises 2 clocks after the input `vga_v_sync` edge of `v_ok` #4.
- All counters wrap nowhere: every counter saturates at 2^CNT_W−1.

## Test plan
- **Nominal lock:** h_total 768, v_total 512, `in_display` 640 clocks × 480 lines, 4 frames. Required:
  - `locked`=1 after the 4th frame start;
  - `h_total`=768, `v_total`=512, `active_w`=640, `active_h`=480.
- **Coordinates:**
  - first active pixel of a frame gives `pix_x`=0, `pix_y`=0, `pix_valid`=1;
  - last active pixel gives 639, 479;
  - blanking gives `pix_valid`=0.
- **Line glitch while locked:** one line shortened to 767 clocks. Required:
  - one-cycle `timing_err`;
  - `locked`=0;
  - relock after 4 further clean frame starts.
- **Timeout:** `vga_h_sync` held low while locked. Required: `timing_err` and `locked`=0 after 1023 clocks.
- **Orphan vsync:** `vga_v_sync` edge without `vga_h_sync`.
  - In SEARCH: no state change.
  - In LOCKED: `timing_err` and loss of lock.
- **Reset mid-frame:** `rst_n` low at pixel (300, 200). Required:
  - all outputs 0 immediately;
  - after release, `pix_valid` stays 0 until the next valid frame start.
